// File: rtl/clock_time_setter_if.sv
// Request and button/readback bundle between the time setter and the clock top level.
// The master side is the requester plus the clock's readback; the slave side is the setter itself.
interface clock_time_setter_if #(
    parameter int W = 7
);
    logic         start;
    logic         alarm_mode;
    logic [W-1:0] tgt_min;
    logic [W-1:0] tgt_hrs;
    logic [W-1:0] tmin;
    logic [W-1:0] thrs;
    logic [W-1:0] amin;
    logic [W-1:0] ahrs;
    logic         Timeset;
    logic         Alarmset;
    logic         Minadv;
    logic         Hrsadv;
    logic         busy;
    logic         done;
    logic         err;

    modport master (
        output start, alarm_mode, tgt_min, tgt_hrs,
        output tmin, thrs, amin, ahrs,
        input  Timeset, Alarmset, Minadv, Hrsadv,
        input  busy, done, err
    );

    modport slave (
        input  start, alarm_mode, tgt_min, tgt_hrs,
        input  tmin, thrs, amin, ahrs,
        output Timeset, Alarmset, Minadv, Hrsadv,
        output busy, done, err
    );
endinterface

// File: rtl/clock_time_setter.sv
// Steps the clock's time counters or alarm registers to a requested HH:MM by driving
// the manual set/advance buttons, then verifies the readback against the target.
module clock_time_setter #(
    parameter int NS = 60,
    parameter int NH = 24,
    parameter int W  = 7
) (
    input  logic               clk,
    input  logic               rst,
    clock_time_setter_if.slave bus
);
    localparam logic [W-1:0] NS_W  = W'(NS);
    localparam logic [W-1:0] NH_W  = W'(NH);
    localparam logic [W-1:0] ONE_W = W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_ADV_MIN,
        S_CALC_H,
        S_ADV_HRS,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t       state_reg;
    logic         mode_reg;
    logic [W-1:0] tgt_min_reg;
    logic [W-1:0] tgt_hrs_reg;
    logic [W-1:0] cnt_reg;
    logic         timeset_reg;
    logic         alarmset_reg;
    logic         minadv_reg;
    logic         hrsadv_reg;
    logic         busy_reg;
    logic         done_reg;
    logic         err_reg;

    logic [W-1:0] cur_min;
    logic [W-1:0] cur_hrs;
    logic [W-1:0] mcnt;
    logic [W-1:0] hcnt;
    logic         range_bad;
    logic         mismatch;

    // Forward distance from cur to tgt modulo m, computed one bit wider so the
    // wrap case never goes through a negative intermediate.
    function automatic logic [W-1:0] mod_diff(
        input logic [W-1:0] tgt,
        input logic [W-1:0] cur,
        input logic [W-1:0] m
    );
        logic [W:0] sum;
        if (tgt >= cur) begin
            sum = {1'b0, tgt} - {1'b0, cur};
        end else begin
            sum = {1'b0, tgt} + {1'b0, m} - {1'b0, cur};
        end
        return sum[W-1:0];
    endfunction

    always_comb begin
        cur_min   = mode_reg ? bus.amin : bus.tmin;
        cur_hrs   = mode_reg ? bus.ahrs : bus.thrs;
        mcnt      = mod_diff(tgt_min_reg, cur_min, NS_W);
        hcnt      = mod_diff(tgt_hrs_reg, cur_hrs, NH_W);
        range_bad = (bus.tgt_min >= NS_W) || (bus.tgt_hrs >= NH_W);
        mismatch  = (cur_min != tgt_min_reg) || (cur_hrs != tgt_hrs_reg);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            mode_reg     <= 1'b0;
            tgt_min_reg  <= '0;
            tgt_hrs_reg  <= '0;
            cnt_reg      <= '0;
            timeset_reg  <= 1'b0;
            alarmset_reg <= 1'b0;
            minadv_reg   <= 1'b0;
            hrsadv_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done_reg <= 1'b0;
                    err_reg  <= 1'b0;
                    if (bus.start) begin
                        if (range_bad) begin
                            done_reg  <= 1'b1;
                            err_reg   <= 1'b1;
                            state_reg <= S_DONE;
                        end else begin
                            mode_reg     <= bus.alarm_mode;
                            tgt_min_reg  <= bus.tgt_min;
                            tgt_hrs_reg  <= bus.tgt_hrs;
                            timeset_reg  <= ~bus.alarm_mode;
                            alarmset_reg <= bus.alarm_mode;
                            busy_reg     <= 1'b1;
                            state_reg    <= S_ARM;
                        end
                    end
                end

                S_ARM: begin
                    if (mcnt != '0) begin
                        minadv_reg <= 1'b1;
                        cnt_reg    <= mcnt - ONE_W;
                        state_reg  <= S_ADV_MIN;
                    end else begin
                        state_reg  <= S_CALC_H;
                    end
                end

                // The button was raised on entry, so a residual count of zero ends the run.
                S_ADV_MIN: begin
                    if (cnt_reg == '0) begin
                        minadv_reg <= 1'b0;
                        state_reg  <= S_CALC_H;
                    end else begin
                        cnt_reg    <= cnt_reg - ONE_W;
                    end
                end

                // Hours are read only now so a minute-wrap carry is already reflected.
                S_CALC_H: begin
                    if (hcnt != '0) begin
                        hrsadv_reg <= 1'b1;
                        cnt_reg    <= hcnt - ONE_W;
                        state_reg  <= S_ADV_HRS;
                    end else begin
                        state_reg  <= S_SETTLE;
                    end
                end

                S_ADV_HRS: begin
                    if (cnt_reg == '0) begin
                        hrsadv_reg <= 1'b0;
                        state_reg  <= S_SETTLE;
                    end else begin
                        cnt_reg    <= cnt_reg - ONE_W;
                    end
                end

                S_SETTLE: begin
                    timeset_reg  <= 1'b0;
                    alarmset_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                    done_reg     <= 1'b1;
                    err_reg      <= mismatch;
                    state_reg    <= S_DONE;
                end

                S_DONE: begin
                    done_reg  <= 1'b0;
                    err_reg   <= 1'b0;
                    state_reg <= S_IDLE;
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.Timeset  = timeset_reg;
    assign bus.Alarmset = alarmset_reg;
    assign bus.Minadv   = minadv_reg;
    assign bus.Hrsadv   = hrsadv_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.err      = err_reg;
endmodule

// File: tb/tb_clock_time_setter.sv
// Drives set requests against a behavioural clock model and predicts step counts,
// latency and result from modular HH:MM arithmetic.
module tb_clock_time_setter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    clock_time_setter_if #(.W(7)) bus ();

    clock_time_setter #(.NS(60), .NH(24), .W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural clock: seconds run unless Timeset is held; minute wrap carries into hours
    // for the time counters, the alarm registers wrap independently.
    int m_tmin = 0, m_thrs = 0, m_amin = 0, m_ahrs = 0, sec = 0;
    bit load_req = 1'b0;
    int ld_tm = 0, ld_th = 0, ld_am = 0, ld_ah = 0;
    bit stuck = 1'b0;
    int stuck_min = 10, stuck_hrs = 10;

    assign bus.tmin = 7'(stuck ? stuck_min : m_tmin);
    assign bus.thrs = 7'(stuck ? stuck_hrs : m_thrs);
    assign bus.amin = 7'(m_amin);
    assign bus.ahrs = 7'(m_ahrs);

    always @(posedge clk) begin
        if (load_req) begin
            m_tmin <= ld_tm; m_thrs <= ld_th; m_amin <= ld_am; m_ahrs <= ld_ah; sec <= 0;
        end else begin
            if (bus.Timeset) begin
                if (bus.Minadv) begin
                    if (m_tmin == 59) begin m_tmin <= 0; m_thrs <= (m_thrs + 1) % 24; end
                    else m_tmin <= m_tmin + 1;
                end else if (bus.Hrsadv) begin
                    m_thrs <= (m_thrs + 1) % 24;
                end
            end else begin
                if (sec == 59) begin
                    sec <= 0;
                    if (m_tmin == 59) begin m_tmin <= 0; m_thrs <= (m_thrs + 1) % 24; end
                    else m_tmin <= m_tmin + 1;
                end else begin
                    sec <= sec + 1;
                end
            end
            if (bus.Alarmset) begin
                if (bus.Minadv) m_amin <= (m_amin + 1) % 60;
                else if (bus.Hrsadv) m_ahrs <= (m_ahrs + 1) % 24;
            end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic preset(input int tm, input int th, input int am, input int ah);
        @(negedge clk);
        ld_tm = tm; ld_th = th; ld_am = am; ld_ah = ah; load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    function automatic int outs_vec();
        return int'({bus.Timeset, bus.Alarmset, bus.Minadv, bus.Hrsadv, bus.busy, bus.done, bus.err});
    endfunction

    task automatic run_txn(input bit mode, input int tg_m, input int tg_h, input bit restart,
                           input string name);
        int set_c = 0, other_c = 0, madv_c = 0, hadv_c = 0, busy_c = 0, bad_c = 0;
        int madv_first = -1, madv_last = -1, hadv_first = -1;
        int done_k = 0, got_err = 0, fin_m = 0, fin_h = 0, sec0, sec1 = 0;
        int extra_done = 0, extra_busy = 0;
        int cur_m, cur_h, m_exp, h_exp, h_after, carry, exp_m, exp_h, exp_err;
        bit range_err;
        range_err = (tg_m >= 60) || (tg_h >= 24);

        @(negedge clk);
        bus.start = 1'b1; bus.alarm_mode = mode;
        bus.tgt_min = 7'(tg_m); bus.tgt_hrs = 7'(tg_h);
        @(negedge clk);
        bus.start = 1'b0; bus.alarm_mode = ~mode;
        bus.tgt_min = 7'($urandom_range(0, 127)); bus.tgt_hrs = 7'($urandom_range(0, 127));
        cur_m = mode ? int'(bus.amin) : int'(bus.tmin);
        cur_h = mode ? int'(bus.ahrs) : int'(bus.thrs);
        sec0  = sec;

        for (int k = 1; k <= 400; k++) begin
            if (bus.done) begin
                done_k = k; got_err = int'(bus.err); sec1 = sec;
                fin_m = mode ? int'(bus.amin) : int'(bus.tmin);
                fin_h = mode ? int'(bus.ahrs) : int'(bus.thrs);
                if (restart) bus.start = 1'b1;
                break;
            end
            set_c   += mode ? int'(bus.Alarmset) : int'(bus.Timeset);
            other_c += mode ? int'(bus.Timeset) : int'(bus.Alarmset);
            busy_c  += int'(bus.busy);
            if (bus.Minadv) begin madv_c++; if (madv_first < 0) madv_first = k; madv_last = k; end
            if (bus.Hrsadv) begin hadv_c++; if (hadv_first < 0) hadv_first = k; end
            if ((bus.Minadv && bus.Hrsadv) ||
                ((bus.Minadv || bus.Hrsadv) && !(bus.Timeset || bus.Alarmset))) bad_c++;
            if (restart && k == 3) bus.start = 1'b1;
            if (restart && k == 4) bus.start = 1'b0;
            @(negedge clk);
        end
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            bus.start = 1'b0;
            extra_done += int'(bus.done);
            extra_busy += int'(bus.busy);
        end

        if (done_k == 0) begin
            check({name, "_timeout"}, 0, 1);
        end else if (range_err) begin
            check({name, "_lat"}, done_k, 1);
            check({name, "_err"}, got_err, 1);
            check({name, "_btn"}, set_c + other_c + madv_c + hadv_c + busy_c, 0);
        end else begin
            m_exp   = (tg_m - cur_m + 60) % 60;
            carry   = (!mode && !stuck && (cur_m + m_exp >= 60)) ? 1 : 0;
            h_after = stuck ? cur_h : (cur_h + carry) % 24;
            h_exp   = (tg_h - h_after + 24) % 24;
            exp_m   = (stuck && !mode) ? stuck_min : tg_m;
            exp_h   = (stuck && !mode) ? stuck_hrs : tg_h;
            exp_err = (exp_m != tg_m || exp_h != tg_h) ? 1 : 0;
            check({name, "_lat"}, done_k, 4 + m_exp + h_exp);
            check({name, "_set"}, set_c, 3 + m_exp + h_exp);
            check({name, "_busy"}, busy_c, 3 + m_exp + h_exp);
            check({name, "_other"}, other_c, 0);
            check({name, "_madv"}, madv_c, m_exp);
            check({name, "_hadv"}, hadv_c, h_exp);
            check({name, "_excl"}, bad_c, 0);
            if (m_exp > 0) begin
                check({name, "_madv_pos"}, madv_first, 2);
                check({name, "_madv_run"}, madv_last - madv_first + 1, m_exp);
            end
            if (h_exp > 0) check({name, "_hadv_pos"}, hadv_first, m_exp + 3);
            check({name, "_err"}, got_err, exp_err);
            check({name, "_min"}, fin_m, exp_m);
            check({name, "_hrs"}, fin_h, exp_h);
            check({name, "_sec"}, (sec1 != sec0) ? 1 : 0, mode ? 1 : 0);
        end
        check({name, "_extra_done"}, extra_done, 0);
        check({name, "_extra_busy"}, extra_busy, 0);
        $display("txn %s mode=%0d tgt=%0d:%0d cur=%0d:%0d done_k=%0d madv=%0d hadv=%0d err=%0d",
                 name, mode, tg_h, tg_m, cur_h, cur_m, done_k, madv_c, hadv_c, got_err);
    endtask

    initial begin
        bus.start = 1'b0; bus.alarm_mode = 1'b0; bus.tgt_min = '0; bus.tgt_hrs = '0;
        repeat (3) @(negedge clk);
        check("reset_outs", outs_vec(), 0);
        rst = 1'b1;

        preset(0, 0, 0, 0);
        run_txn(1'b0, 45, 13, 1'b0, "time_13_45");
        preset(12, 3, 30, 7);
        run_txn(1'b1, 30, 7, 1'b0, "alarm_equal");
        preset(50, 23, 0, 0);
        run_txn(1'b0, 5, 0, 1'b0, "wrap_00_05");
        run_txn(1'b0, 60, 5, 1'b0, "range_min");
        run_txn(1'b1, 5, 24, 1'b0, "range_hrs");
        stuck = 1'b1;
        run_txn(1'b0, 20, 10, 1'b0, "stuck_10_10");
        stuck = 1'b0;
        preset(0, 0, 0, 0);
        run_txn(1'b0, 20, 3, 1'b1, "restart");

        // Asynchronous reset in the middle of the minute phase.
        preset(0, 0, 0, 0);
        @(negedge clk);
        bus.start = 1'b1; bus.alarm_mode = 1'b0; bus.tgt_min = 7'd40; bus.tgt_hrs = 7'd2;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_rst_minadv", int'(bus.Minadv), 1);
        #2 rst = 1'b0;
        #1 check("rst_async", outs_vec(), 0);
        @(negedge clk);
        check("rst_held", outs_vec(), 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_idle", outs_vec(), 0);
        $display("txn rst_mid_adv tmin=%0d thrs=%0d", m_tmin, m_thrs);

        for (int r = 0; r < 16; r++) begin
            int tm, th;
            preset($urandom_range(0, 59), $urandom_range(0, 23),
                   $urandom_range(0, 59), $urandom_range(0, 23));
            tm = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 127) : $urandom_range(0, 59);
            th = ($urandom_range(0, 7) == 0) ? $urandom_range(24, 127) : $urandom_range(0, 23);
            run_txn(1'($urandom_range(0, 1)), tm, th, 1'($urandom_range(0, 1)),
                    $sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/clock_time_setter.md
Name: clock_time_setter

Overview:
- Automated initiator for the digital clock's manual-button interface. It drives Timeset, Alarmset, Minadv and Hrsadv the way a user would.
- It steps the time counters or the alarm registers to a requested HH:MM, reads back the counter values to compute the step counts, and checks the result.
- Sits beside the clock top level and shares its one-pulse-per-second clock. Used for power-on/sync presets and self-test.

Parameters:
- NS, 60, minutes modulus.
- NH, 24, hours modulus.
- W, 7, width of every time value.

Ports:
- clk  in  1  clock pulse, same domain as the clock counters.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- alarm_mode  in  1  0 = set time counters, 1 = set alarm registers; latched on start.
- tgt_min  in  W  target minutes.
- tgt_hrs  in  W  target hours.
- tmin  in  W  readback, time minutes.
- thrs  in  W  readback, time hours.
- amin  in  W  readback, alarm minutes.
- ahrs  in  W  readback, alarm hours.
- Timeset  out  1  time-set button.
- Alarmset  out  1  alarm-set button.
- Minadv  out  1  minute-advance button.
- Hrsadv  out  1  hour-advance button.
- busy  out  1  high from the cycle after start until DONE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: 1 = range error or verify mismatch.

Behaviour:
- All outputs are registered. Reset (rst=0) asynchronously forces every output to 0 and the FSM to IDLE, including mid-sequence; the clock keeps whatever partial value it reached.
- "set" below means Timeset when alarm_mode=0, Alarmset when alarm_mode=1. The other one stays 0 throughout.
- Readback (cur_min/cur_hrs) is tmin/thrs in time mode, amin/ahrs in alarm mode.
- Minadv and Hrsadv are never both high. Neither is ever high while set is low.
- IDLE: all outputs 0.
  - start=1 with tgt_min>=NS or tgt_hrs>=NH: go to DONE with err=1; set is never asserted.
  - Otherwise: latch targets and mode; set=1, busy=1; go to ARM.
- ARM (1 cycle): set=1, adv=0. Compute mcnt=(tgt_min-cur_min) mod NS in W bits, no negative intermediates. Go to ADV_MIN if mcnt>0, else CALC_H.
- ADV_MIN: Minadv=1 for exactly mcnt cycles, counted by an internal down-counter; then CALC_H.
- CALC_H (1 cycle): set=1, adv=0. Re-read cur_hrs, which absorbs any minute-wrap carry. Compute hcnt=(tgt_hrs-cur_hrs) mod NH. Go to ADV_HRS if hcnt>0, else SETTLE.
- ADV_HRS: Hrsadv=1 for exactly hcnt cycles; then SETTLE.
- SETTLE (1 cycle): set=1, adv=0. Compare cur_min/cur_hrs against the targets.
- DONE (1 cycle): set=0, busy=0, done=1, err=mismatch. Return to IDLE.
- Latency from the start edge to the done cycle is 4+mcnt+hcnt cycles. On the range-error path, done rises 1 cycle after start.
- start while busy, or during DONE, is ignored (not queued).
- Target inputs may change after start without effect.
- Seconds are never touched. In time mode, holding Timeset freezes the seconds counter for the whole sequence.

Test Plan:
- Time mode, readback 00:00, target 13:45 -> Timeset high 61 cycles; Minadv high 45 consecutive cycles; Hrsadv high 13 cycles; done=1, err=0 at cycle 62; readback 13:45.
- Alarm mode, alarm 07:30, target 07:30 -> Alarmset high 3 cycles, no adv pulses, done at cycle 4, err=0; Timeset stays 0; time seconds keep running.
- Time mode, readback 23:50, target 00:05 -> Minadv high 15 cycles; hcnt equals 1 without carry, 0 with carry, computed after minute phase; final readback 00:05, err=0.
- tgt_min=60 (or tgt_hrs=24) -> done=1, err=1 one cycle after start; Timeset/Alarmset/Minadv/Hrsadv never high.
- Readback forced stuck at 10:10, target 10:20 -> 10 Minadv cycles, then done=1, err=1 (verify mismatch).
- rst low during ADV_MIN -> all outputs 0 immediately, without a clock edge. Second start pulse while busy is ignored: exactly one done per accepted start.
